// File: rtl/freq_gen_pkg.sv
// Shared types and constants for the programmable square-wave generator.
package freq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    APPLY
  } fg_state_e;

  localparam int FREQ_W   = 32;
  localparam int DIV_W    = FREQ_W + 1;
  localparam int MIN_HALF = 1;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, fixed N_W-cycle latency.
module seq_divider
  import freq_gen_pkg::*;
#(
  parameter int N_W = FREQ_W,
  parameter int D_W = DIV_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  input  logic [N_W-1:0] num_i,
  input  logic [D_W-1:0] den_i,
  output logic           done_o,
  output logic [N_W-1:0] quot_o
);

  localparam int CNT_W = (N_W > 1) ? $clog2(N_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [D_W-1:0]   rem_q;
  logic [N_W-1:0]   num_q;
  logic [D_W-1:0]   den_q;
  logic [N_W-1:0]   quot_q;

  logic [D_W:0]     trial_d;
  logic             ge_d;
  logic [D_W-1:0]   rem_d;

  // Shift the next numerator bit into the partial remainder and try a subtract.
  // The remainder stays below the denominator, so it always fits in D_W bits.
  always_comb begin
    trial_d = {rem_q, num_q[N_W-1]};
    ge_d    = (trial_d >= {1'b0, den_q});
    rem_d   = ge_d ? D_W'(trial_d - {1'b0, den_q}) : trial_d[D_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
      end else if (busy_q) begin
        cnt_q <= cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      rem_q  <= '0;
      num_q  <= num_i;
      den_q  <= den_i;
      quot_q <= '0;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      num_q  <= {num_q[N_W-2:0], 1'b0};
      quot_q <= {quot_q[N_W-2:0], ge_d};
    end
  end

  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/freq_generator.sv
// Programmable 50%-duty square-wave generator; frequency changes land only on
// half-period boundaries so every phase is a whole old or whole new half-period.
module freq_generator
  import freq_gen_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 200000000,
  parameter int          FREQ_WIDTH = FREQ_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FREQ_WIDTH-1:0] freq_in,
  input  logic                  freq_valid,
  output logic                  freq_ready,
  output logic                  out_signal,
  output logic                  running,
  output logic [FREQ_WIDTH-1:0] half_period
);

  localparam int DEN_W = FREQ_WIDTH + 1;
  localparam logic [FREQ_WIDTH-1:0] NUM = FREQ_WIDTH'(CLOCK_FREQ);
  localparam logic [FREQ_WIDTH-1:0] ONE = FREQ_WIDTH'(1);

  fg_state_e             state_q;
  logic                  ready_q;
  logic                  out_q;
  logic                  run_q;
  logic                  stop_q;
  logic [FREQ_WIDTH-1:0] half_q;
  logic [FREQ_WIDTH-1:0] cnt_q;
  logic [FREQ_WIDTH-1:0] pend_q;

  logic                  accept_d;
  logic                  div_start_d;
  logic                  div_done;
  logic [FREQ_WIDTH-1:0] div_quot;

  function automatic logic [FREQ_WIDTH-1:0] clamp_half(input logic [FREQ_WIDTH-1:0] q);
    return (q < FREQ_WIDTH'(MIN_HALF)) ? FREQ_WIDTH'(MIN_HALF) : q;
  endfunction

  assign accept_d    = freq_valid && ready_q;
  assign div_start_d = accept_d && (freq_in != '0);

  seq_divider #(
    .N_W (FREQ_WIDTH),
    .D_W (DEN_W)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .start_i (div_start_d),
    .num_i   (NUM),
    .den_i   ({freq_in, 1'b0}),
    .done_o  (div_done),
    .quot_o  (div_quot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      out_q   <= 1'b0;
      run_q   <= 1'b0;
      stop_q  <= 1'b0;
      half_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      // Free-running generator; APPLY below overrides it on a switch boundary.
      if (run_q) begin
        if (cnt_q == '0) begin
          out_q <= ~out_q;
          cnt_q <= half_q - ONE;
        end else begin
          cnt_q <= cnt_q - ONE;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (accept_d) begin
            ready_q <= 1'b0;
            stop_q  <= (freq_in == '0);
            state_q <= (freq_in == '0) ? APPLY : DIVIDE;
          end
        end
        DIVIDE: begin
          if (div_done) begin
            pend_q  <= clamp_half(div_quot);
            state_q <= APPLY;
          end
        end
        APPLY: begin
          if (!run_q) begin
            if (!stop_q) begin
              half_q <= pend_q;
              out_q  <= 1'b1;
              run_q  <= 1'b1;
              cnt_q  <= pend_q - ONE;
            end
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else if (cnt_q == '0) begin
            if (stop_q) begin
              out_q  <= 1'b0;
              run_q  <= 1'b0;
              half_q <= '0;
              cnt_q  <= '0;
            end else begin
              out_q  <= ~out_q;
              half_q <= pend_q;
              cnt_q  <= pend_q - ONE;
            end
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign freq_ready  = ready_q;
  assign out_signal  = out_q;
  assign running     = run_q;
  assign half_period = half_q;

endmodule

// File: tb/tb_freq_generator.sv
// Directed plus randomized bench for freq_generator with a behavioural phase-length model.
module tb_freq_generator;

  localparam int unsigned CLK_HZ = 1000;
  localparam int          FW     = 32;
  localparam int          LIMIT  = 2000;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] freq_in;
  logic          freq_valid;
  logic          freq_ready;
  logic          out_signal;
  logic          running;
  logic [FW-1:0] half_period;

  int tests = 0;
  int fails = 0;

  freq_generator #(
    .CLOCK_FREQ (CLK_HZ),
    .FREQ_WIDTH (FW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .freq_in     (freq_in),
    .freq_valid  (freq_valid),
    .freq_ready  (freq_ready),
    .out_signal  (out_signal),
    .running     (running),
    .half_period (half_period)
  );

  always #5 clk = ~clk;

  // Expected half-period: floor(clock / (2*f)), never below one cycle; 0 means stopped.
  function automatic longint model_half(input longint f);
    longint q;
    if (f == 0) return 0;
    q = CLK_HZ / (2 * f);
    return (q < 1) ? 1 : q;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns at a negedge sample where freq_ready is high (or after the bound).
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (freq_ready !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check(tag, freq_ready, 1);
  endtask

  task automatic send(input logic [FW-1:0] f);
    wait_ready("send_ready");
    freq_valid = 1'b1;
    freq_in    = f;
    @(posedge clk);
    #1 freq_valid = 1'b0;
  endtask

  // Called at the first sample of a phase; ends at the first sample of the next one.
  task automatic phase_len(output int len);
    logic v;
    v   = out_signal;
    len = 0;
    while (out_signal === v && len < LIMIT) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic sync_edge();
    logic v;
    int   n;
    v = out_signal;
    n = 0;
    while (out_signal === v && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int          len;
    int          cnt;
    int          highs;
    logic        r;
    int unsigned f;

    reset      = 1'b1;
    freq_valid = 1'b0;
    freq_in    = '0;
    repeat (3) @(negedge clk);
    check("rst_out", out_signal, 0);
    check("rst_running", running, 0);
    check("rst_half", half_period, 0);
    check("rst_ready", freq_ready, 1);
    reset = 1'b0;

    // Request 100 Hz from stopped: ready low FW+2 samples, then first rising edge.
    send(32'd100);
    cnt = 0;
    @(negedge clk);
    while (freq_ready !== 1'b1 && cnt < LIMIT) begin
      cnt++;
      @(negedge clk);
    end
    check("start_latency", cnt, FW + 2);
    check("start_out", out_signal, 1);
    check("start_running", running, 1);
    check("start_half", half_period, model_half(100));
    for (int i = 0; i < 3; i++) begin
      phase_len(len);
      check("p100_phase", len, model_half(100));
    end

    // Request 600 Hz: quotient 0 clamps to one cycle.
    send(32'd600);
    wait_ready("p600_ready");
    check("p600_half", half_period, model_half(600));
    for (int i = 0; i < 2; i++) begin
      phase_len(len);
      check("p600_phase", len, 1);
    end

    // Back to 100 Hz, then switch to 3 Hz; old phases stay intact.
    send(32'd100);
    wait_ready("p100b_ready");
    send(32'd3);
    sync_edge();
    r = 1'b0;
    for (int i = 0; i < 20; i++) begin
      r = freq_ready;
      phase_len(len);
      if (r) break;
      check("pre_switch_phase", len, model_half(100));
    end
    check("switch_ready", r, 1);
    check("switch_phase", len, model_half(3));
    phase_len(len);
    check("p3_phase", len, model_half(3));

    // Stop while running at 100 Hz with the output high.
    send(32'd100);
    wait_ready("p100c_ready");
    @(negedge clk);
    while (!(out_signal === 1'b1 && half_period == 5)) @(negedge clk);
    sync_edge();
    if (out_signal !== 1'b1) sync_edge();
    freq_valid = 1'b1;
    freq_in    = '0;
    @(posedge clk);
    #1 freq_valid = 1'b0;
    @(negedge clk);
    highs = 1;
    while (out_signal === 1'b1 && highs < LIMIT) begin
      highs++;
      @(negedge clk);
    end
    check("stop_last_high", highs, model_half(100));
    check("stop_running", running, 0);
    check("stop_half", half_period, 0);
    check("stop_ready", freq_ready, 1);
    highs = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_signal !== 1'b0) highs++;
    end
    check("stop_held_low", highs, 0);

    // Reset 10 cycles into a divide while running.
    send(32'd100);
    wait_ready("p100d_ready");
    send(32'd20);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out", out_signal, 0);
    check("mid_rst_running", running, 0);
    check("mid_rst_half", half_period, 0);
    check("mid_rst_ready", freq_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    highs = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_signal !== 1'b0 || running !== 1'b0) highs++;
    end
    check("post_rst_quiet", highs, 0);
    send(32'd50);
    wait_ready("p50_ready");
    check("p50_half", half_period, model_half(50));
    phase_len(len);
    check("p50_phase", len, model_half(50));

    // Hold valid through the divide with a different value; first request lands first.
    wait_ready("hold_ready");
    freq_valid = 1'b1;
    freq_in    = 32'd100;
    @(posedge clk);
    #1 freq_in = 32'd250;
    wait_ready("hold_first_ready");
    check("hold_first_half", half_period, model_half(100));
    @(posedge clk);
    #1 freq_valid = 1'b0;
    @(negedge clk);
    check("hold_second_accepted", freq_ready, 0);
    wait_ready("hold_second_ready");
    check("hold_second_half", half_period, model_half(250));
    phase_len(len);
    check("hold_second_phase", len, model_half(250));

    // Randomized retunes while running.
    for (int i = 0; i < 8; i++) begin
      f = $urandom_range(600, 10);
      repeat ($urandom_range(7, 0)) @(negedge clk);
      send(f);
      wait_ready("rnd_ready");
      check("rnd_half", half_period, model_half(f));
      phase_len(len);
      check("rnd_phase", len, model_half(f));
      phase_len(len);
      check("rnd_phase2", len, model_half(f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
